// File: rtl/camera_pkg.sv
// Shared types and constants for the camera readout path: frame geometry,
// capture/serializer state encodings and the bank memory addressing helper.
package camera_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int PIX_PER_FRAME  = 4;
    localparam int NUM_BANKS      = 2;
    localparam logic [1:0] LAST_IDX = 2'(PIX_PER_FRAME - 1);

    typedef enum logic {
        WAIT_R1 = 1'b0,
        WAIT_R2 = 1'b1
    } cap_state_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Bit offset of pixel idx of a bank inside the flattened bank memory.
    function automatic int unsigned pix_base(input logic bank, input logic [1:0] idx,
                                             input int unsigned data_w);
        return ({31'd0, bank} * $unsigned(PIX_PER_FRAME) + {30'd0, idx}) * data_w;
    endfunction

endpackage

// File: rtl/pixel_serializer.sv
// Streams buffered frames one pixel per beat over valid/ready, draining the
// oldest full bank first and releasing it on its accepted last beat.
module pixel_serializer
    import camera_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [1:0]                            bank_full_nxt,
    input  logic                                  oldest_nxt,
    input  logic [NUM_BANKS*PIX_PER_FRAME*DATA_W-1:0] mem_nxt,
    input  logic                                  pix_ready,
    output logic [DATA_W-1:0]                     pix_data,
    output logic                                  pix_valid,
    output logic                                  pix_last,
    output logic                                  free_pulse,
    output logic                                  free_bank
);

    ser_state_t        state_r, state_s;
    logic              bank_r, bank_s, sel_bank_s;
    logic [1:0]        idx_r, idx_s, next_idx_s;
    logic [DATA_W-1:0] data_r, data_s;
    logic              valid_r, valid_s, last_r, last_s;
    logic              accept_s, start_s, step_s;

    assign accept_s   = valid_r & pix_ready;
    assign free_pulse = accept_s & last_r;
    assign free_bank  = bank_r;
    assign pix_data   = data_r;
    assign pix_valid  = valid_r;
    assign pix_last   = last_r;

    // Next-beat decision; bank fullness is the look-ahead value so a frame
    // completing this cycle is presented on the very next cycle.
    always_comb begin
        state_s    = state_r;
        bank_s     = bank_r;
        idx_s      = idx_r;
        data_s     = data_r;
        valid_s    = valid_r;
        last_s     = last_r;
        start_s    = 1'b0;
        step_s     = 1'b0;
        next_idx_s = idx_r + 2'd1;
        sel_bank_s = (&bank_full_nxt) ? oldest_nxt : bank_full_nxt[1];
        case (state_r)
            IDLE: start_s = |bank_full_nxt;
            SEND: begin
                if (accept_s && last_r) begin
                    start_s = |bank_full_nxt;
                end else if (accept_s) begin
                    step_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            default: start_s = 1'b0;
        endcase
        if (start_s) begin
            state_s = SEND;
            bank_s  = sel_bank_s;
            idx_s   = 2'd0;
            data_s  = mem_nxt[pix_base(sel_bank_s, 2'd0, $unsigned(DATA_W)) +: DATA_W];
            valid_s = 1'b1;
            last_s  = 1'b0;
        end else if (step_s) begin
            idx_s  = next_idx_s;
            data_s = mem_nxt[pix_base(bank_r, next_idx_s, $unsigned(DATA_W)) +: DATA_W];
            last_s = (next_idx_s == LAST_IDX);
        end else if (state_r == SEND && !accept_s) begin
            state_s = SEND;
        end else begin
            state_s = IDLE;
            idx_s   = 2'd0;
            valid_s = 1'b0;
            last_s  = 1'b0;
        end
    end

    // Serializer state and registered stream outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            bank_r  <= 1'b0;
            idx_r   <= 2'd0;
            data_r  <= '0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            bank_r  <= bank_s;
            idx_r   <= idx_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            last_r  <= last_s;
        end
    end

endmodule

// File: rtl/pixel_readout_buffer.sv
// Captures 2x2 frames from the column ADCs into a ping-pong buffer and
// streams them out; tracks sticky overflow and row-sequence error flags.
module pixel_readout_buffer
    import camera_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ADC,
    input  logic              NRE_1,
    input  logic              NRE_2,
    input  logic              Erase,
    input  logic [DATA_W-1:0] Col1_data,
    input  logic [DATA_W-1:0] Col2_data,
    input  logic              Clr_flags,
    output logic [DATA_W-1:0] Pix_data,
    output logic              Pix_valid,
    input  logic              Pix_ready,
    output logic              Pix_last,
    output logic              Ovf,
    output logic              Seq_err
);

    localparam int MEM_W = NUM_BANKS * PIX_PER_FRAME * DATA_W;

    cap_state_t        cap_state_r, cap_state_s;
    logic              adc_prev_r, adc_evt_s;
    logic              row1_s, row2_s, both_s;
    logic              load_r1_s, frame_done_s, seq_err_set_s;
    logic [DATA_W-1:0] r1c1_r, r1c2_r;
    logic [MEM_W-1:0]  mem_r, mem_nxt_s;
    logic [1:0]        bank_full_r, bank_full_nxt_s, free_mask_s, full_kept_s;
    logic              oldest_r, oldest_nxt_s;
    logic              wr_en_s, wr_bank_s, ovf_set_s;
    logic              free_pulse_s, free_bank_s;
    logic              ovf_r, seq_err_r;

    assign adc_evt_s = ADC & ~adc_prev_r;
    assign row1_s    = ~NRE_1 &  NRE_2;
    assign row2_s    =  NRE_1 & ~NRE_2;
    assign both_s    = ~NRE_1 & ~NRE_2;
    assign Ovf       = ovf_r;
    assign Seq_err   = seq_err_r;

    // Row capture sequencing; Erase dominates and suppresses capture events.
    always_comb begin
        cap_state_s   = cap_state_r;
        load_r1_s     = 1'b0;
        frame_done_s  = 1'b0;
        seq_err_set_s = 1'b0;
        if (Erase) begin
            cap_state_s = WAIT_R1;
        end else if (adc_evt_s) begin
            case (cap_state_r)
                WAIT_R1: begin
                    if (row1_s) begin
                        load_r1_s   = 1'b1;
                        cap_state_s = WAIT_R2;
                    end else if (row2_s || both_s) begin
                        seq_err_set_s = 1'b1;
                    end else begin
                        cap_state_s = WAIT_R1;
                    end
                end
                WAIT_R2: begin
                    if (row2_s) begin
                        frame_done_s = 1'b1;
                        cap_state_s  = WAIT_R1;
                    end else if (row1_s || both_s) begin
                        seq_err_set_s = 1'b1;
                    end else begin
                        cap_state_s = WAIT_R2;
                    end
                end
                default: cap_state_s = WAIT_R1;
            endcase
        end else begin
            cap_state_s = cap_state_r;
        end
    end

    // Bank allocation: a bank released this cycle may take the completing frame.
    always_comb begin
        free_mask_s = free_pulse_s ? (free_bank_s ? 2'b10 : 2'b01) : 2'b00;
        full_kept_s = bank_full_r & ~free_mask_s;
        wr_en_s     = 1'b0;
        wr_bank_s   = 1'b0;
        ovf_set_s   = 1'b0;
        if (frame_done_s) begin
            if (!full_kept_s[0]) begin
                wr_en_s = 1'b1;
            end else if (!full_kept_s[1]) begin
                wr_en_s   = 1'b1;
                wr_bank_s = 1'b1;
            end else begin
                ovf_set_s = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end
        bank_full_nxt_s = full_kept_s | (wr_en_s ? (wr_bank_s ? 2'b10 : 2'b01) : 2'b00);
        case (full_kept_s)
            2'b01:   oldest_nxt_s = 1'b0;
            2'b10:   oldest_nxt_s = 1'b1;
            2'b00:   oldest_nxt_s = wr_en_s ? wr_bank_s : oldest_r;
            default: oldest_nxt_s = oldest_r;
        endcase
        mem_nxt_s = mem_r;
        if (wr_en_s) begin
            mem_nxt_s[pix_base(wr_bank_s, 2'd0, $unsigned(DATA_W)) +: DATA_W] = r1c1_r;
            mem_nxt_s[pix_base(wr_bank_s, 2'd1, $unsigned(DATA_W)) +: DATA_W] = r1c2_r;
            mem_nxt_s[pix_base(wr_bank_s, 2'd2, $unsigned(DATA_W)) +: DATA_W] = Col1_data;
            mem_nxt_s[pix_base(wr_bank_s, 2'd3, $unsigned(DATA_W)) +: DATA_W] = Col2_data;
        end else begin
            mem_nxt_s = mem_r;
        end
    end

    // Capture, buffer and sticky-flag registers; a flag set beats a clear.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            adc_prev_r  <= 1'b0;
            cap_state_r <= WAIT_R1;
            r1c1_r      <= '0;
            r1c2_r      <= '0;
            mem_r       <= '0;
            bank_full_r <= 2'b00;
            oldest_r    <= 1'b0;
            ovf_r       <= 1'b0;
            seq_err_r   <= 1'b0;
        end else begin
            adc_prev_r  <= ADC;
            cap_state_r <= cap_state_s;
            if (load_r1_s) begin
                r1c1_r <= Col1_data;
                r1c2_r <= Col2_data;
            end
            mem_r       <= mem_nxt_s;
            bank_full_r <= bank_full_nxt_s;
            oldest_r    <= oldest_nxt_s;
            ovf_r       <= ovf_set_s | (ovf_r & ~Clr_flags);
            seq_err_r   <= seq_err_set_s | (seq_err_r & ~Clr_flags);
        end
    end

    pixel_serializer #(.DATA_W(DATA_W)) u_serializer (
        .clk           (Clk),
        .rst_n         (Reset),
        .bank_full_nxt (bank_full_nxt_s),
        .oldest_nxt    (oldest_nxt_s),
        .mem_nxt       (mem_nxt_s),
        .pix_ready     (Pix_ready),
        .pix_data      (Pix_data),
        .pix_valid     (Pix_valid),
        .pix_last      (Pix_last),
        .free_pulse    (free_pulse_s),
        .free_bank     (free_bank_s)
    );

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Directed bench for pixel_readout_buffer: expected beats are queued as frames
// are driven and compared against beats the monitor sees accepted.
module tb_pixel_readout_buffer;

    typedef struct {
        logic [8:0] beat;
        int         cyc;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset, adc, nre_1, nre_2, erase, clr_flags, pix_ready;
    logic [7:0] col1, col2, pix_data;
    logic       pix_valid, pix_last, ovf, seq_err;

    logic [8:0] exp_q[$];
    obs_t       obs_q[$];
    int         tests = 0;
    int         fails = 0;
    int         stall_err = 0;
    int         cyc = 0;
    logic       pv_r = 1'b0;
    logic       pr_r = 1'b0;
    logic [8:0] pb_r = 9'd0;

    pixel_readout_buffer #(.DATA_W(8)) dut (
        .Clk       (clk),
        .Reset     (reset),
        .ADC       (adc),
        .NRE_1     (nre_1),
        .NRE_2     (nre_2),
        .Erase     (erase),
        .Col1_data (col1),
        .Col2_data (col2),
        .Clr_flags (clr_flags),
        .Pix_data  (pix_data),
        .Pix_valid (pix_valid),
        .Pix_ready (pix_ready),
        .Pix_last  (pix_last),
        .Ovf       (ovf),
        .Seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat monitor plus hold-while-stalled check.
    always @(negedge clk) begin
        if (!reset) begin
            pv_r <= 1'b0;
        end else begin
            if (pv_r && !pr_r && !(pix_valid && ({pix_last, pix_data} === pb_r)))
                stall_err <= stall_err + 1;
            if (pix_valid && pix_ready)
                obs_q.push_back('{beat: {pix_last, pix_data}, cyc: cyc});
            pv_r <= pix_valid;
            pr_r <= pix_ready;
            pb_r <= {pix_last, pix_data};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic capture(input logic n1, input logic n2, input logic [7:0] d1, input logic [7:0] d2);
        nre_1 = n1; nre_2 = n2; col1 = d1; col2 = d2; adc = 1'b1;
        tick();
        adc = 1'b0; nre_1 = 1'b1; nre_2 = 1'b1;
        tick();
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input bit expect_out);
        if (expect_out) begin
            exp_q.push_back({1'b0, a});
            exp_q.push_back({1'b0, b});
            exp_q.push_back({1'b0, c});
            exp_q.push_back({1'b1, d});
        end
        capture(1'b0, 1'b1, a, b);
        capture(1'b1, 1'b0, c, d);
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        wait_obs(exp_q.size(), budget);
        repeat (6) tick();
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            obs_t       o;
            logic [8:0] e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_beat"}, {23'd0, o.beat}, {23'd0, e});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b0; adc = 1'b0; nre_1 = 1'b1; nre_2 = 1'b1; erase = 1'b0;
        clr_flags = 1'b0; pix_ready = 1'b0; col1 = 8'd0; col2 = 8'd0;
        repeat (3) tick();
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_last", 32'(pix_last), 32'd0);
        chk("rst_data", 32'(pix_data), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        reset = 1'b1;
        tick();

        // Basic frame, ready held high, first pixel the cycle after completion.
        pix_ready = 1'b1;
        exp_q.push_back(9'h011); exp_q.push_back(9'h022);
        exp_q.push_back(9'h033); exp_q.push_back(9'h144);
        capture(1'b0, 1'b1, 8'h11, 8'h22);
        nre_1 = 1'b1; nre_2 = 1'b0; col1 = 8'h33; col2 = 8'h44; adc = 1'b1;
        tick();
        chk("t1_latency_valid", 32'(pix_valid), 32'd1);
        chk("t1_latency_data", 32'(pix_data), 32'h11);
        adc = 1'b0; nre_2 = 1'b1;
        tick();
        wait_obs(4, 20);
        chk("t1_back2back", (obs_q.size() >= 4) ? 32'(obs_q[3].cyc - obs_q[0].cyc) : 32'hFFFF_FFFF, 32'd3);
        drain("t1", 20);

        // Ready toggling: data held during stalls, exactly four beats.
        pix_ready = 1'b0;
        frame(8'h55, 8'h66, 8'h77, 8'h88, 1'b1);
        for (int i = 0; i < 12; i++) begin
            pix_ready = (i % 2 == 1);
            tick();
        end
        pix_ready = 1'b1;
        drain("t2", 20);

        // Three frames with no drain: the third is dropped.
        pix_ready = 1'b0;
        frame(8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b1);
        frame(8'hB0, 8'hB1, 8'hB2, 8'hB3, 1'b1);
        chk("t3_no_ovf_yet", 32'(ovf), 32'd0);
        frame(8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b0);
        chk("t3_ovf_set", 32'(ovf), 32'd1);
        pix_ready = 1'b1;
        drain("t3", 40);
        clear_flags();
        chk("t3_ovf_clr", 32'(ovf), 32'd0);

        // Sequence errors: row2 first, both rows, set beats clear.
        capture(1'b1, 1'b0, 8'hE1, 8'hE2);
        chk("t4_row2_first", 32'(seq_err), 32'd1);
        clear_flags();
        chk("t4_clr", 32'(seq_err), 32'd0);
        capture(1'b0, 1'b0, 8'hE3, 8'hE4);
        chk("t4_both_rows", 32'(seq_err), 32'd1);
        repeat (4) tick();
        chk("t4_no_output", 32'(obs_q.size()), 32'd0);
        clear_flags();
        chk("t4_clr2", 32'(seq_err), 32'd0);
        nre_2 = 1'b0; adc = 1'b1; clr_flags = 1'b1;
        tick();
        adc = 1'b0; nre_2 = 1'b1; clr_flags = 1'b0;
        tick();
        chk("t4_set_wins", 32'(seq_err), 32'd1);
        clear_flags();
        exp_q.push_back(9'h001); exp_q.push_back(9'h002);
        exp_q.push_back(9'h003); exp_q.push_back(9'h104);
        capture(1'b0, 1'b1, 8'h01, 8'h02);
        capture(1'b0, 1'b1, 8'h0E, 8'h0F);
        chk("t4_row1_twice", 32'(seq_err), 32'd1);
        capture(1'b1, 1'b0, 8'h03, 8'h04);
        drain("t4", 20);
        clear_flags();

        // Erase discards partial row-1 data.
        capture(1'b0, 1'b1, 8'hAA, 8'hBB);
        erase = 1'b1;
        tick();
        erase = 1'b0;
        frame(8'hC1, 8'hC2, 8'hD1, 8'hD2, 1'b1);
        chk("t5_no_seq_err", 32'(seq_err), 32'd0);
        drain("t5", 20);

        // ADC held high: single capture; then reset mid-stream.
        pix_ready = 1'b0;
        nre_1 = 1'b0; col1 = 8'h5A; col2 = 8'hA5; adc = 1'b1;
        repeat (5) tick();
        adc = 1'b0; nre_1 = 1'b1;
        tick();
        capture(1'b1, 1'b0, 8'h3C, 8'hC3);
        chk("t6_single_capture", 32'(seq_err), 32'd0);
        exp_q.push_back(9'h05A); exp_q.push_back(9'h0A5);
        pix_ready = 1'b1;
        repeat (2) tick();
        pix_ready = 1'b0; reset = 1'b0;
        tick();
        chk("t6_rst_valid", 32'(pix_valid), 32'd0);
        chk("t6_rst_data", 32'(pix_data), 32'd0);
        reset = 1'b1; pix_ready = 1'b1;
        drain("t6", 20);
        chk("t6_idle_after_rst", 32'(pix_valid), 32'd0);

        chk("stall_hold", 32'(stall_err), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
